// File: rtl/ysyx_22041461_icache_nway_if.sv
// Bus interfaces of the N-way instruction cache: the IFU fetch/response
// channel and the line-refill channel towards memory.
interface ysyx_22041461_icache_nway_ifu_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_inst;

    modport master (output flush, req_valid, req_pc,
                    input  req_ready, resp_valid, resp_inst);
    modport slave  (input  flush, req_valid, req_pc,
                    output req_ready, resp_valid, resp_inst);
endinterface

interface ysyx_22041461_icache_nway_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;

    modport master (output mem_req_valid, mem_req_addr,
                    input  mem_req_ready, mem_rsp_valid, mem_rsp_data);
    modport slave  (input  mem_req_valid, mem_req_addr,
                    output mem_req_ready, mem_rsp_valid, mem_rsp_data);
endinterface

// File: rtl/ysyx_22041461_icache_nway.sv
// Parametrised N-way set-associative instruction cache with round-robin
// replacement, multi-beat refill, fence.i flush and hit/miss counters.
module ysyx_22041461_icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    ysyx_22041461_icache_nway_ifu_if.slave         ifu,
    ysyx_22041461_icache_nway_mem_if.master        mem,
    output logic [31:0]                            hit_cnt,
    output logic [31:0]                            miss_cnt
);
    localparam int OFF_W  = $clog2(LINE_WORDS * 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 64 - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESP
    } state_t;

    state_t              state_reg;
    logic [63:0]         pc_reg;
    logic [WAY_W-1:0]    victim_reg;
    logic [WORD_W-1:0]   beat_reg;
    logic                flush_seen_reg;
    logic                mem_req_valid_reg;
    logic [63:0]         mem_req_addr_reg;
    logic [31:0]         resp_inst_reg;
    logic [31:0]         hit_cnt_reg;
    logic [31:0]         miss_cnt_reg;

    logic                valid_reg [SETS][WAYS];
    logic [TAG_W-1:0]    tag_reg   [SETS][WAYS];
    logic [WAY_W-1:0]    rr_reg    [SETS];
    logic [63:0]         data_reg  [SETS][WAYS][LINE_WORDS];

    logic [IDX_W-1:0]    set_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [WORD_W-1:0]   word_sel;
    logic                misaligned;
    logic [WAYS-1:0]     hit_vec;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_next;
    logic                victim_was_valid;
    logic [WAY_W-1:0]    rr_next;
    logic [WAY_W-1:0]    rd_way;
    logic [63:0]         rd_word;
    logic [31:0]         resp_inst_next;
    logic                last_beat;

    assign set_idx    = pc_reg[IDX_W+OFF_W-1:OFF_W];
    assign pc_tag     = pc_reg[63:IDX_W+OFF_W];
    assign misaligned = (pc_reg[1:0] != 2'b00);

    generate
        if (LINE_WORDS > 1) begin : g_word
            assign word_sel = pc_reg[OFF_W-1:3];
        end else begin : g_word1
            assign word_sel = '0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign hit_vec[gi] = valid_reg[set_idx][gi] && (tag_reg[set_idx][gi] == pc_tag);
        end
    endgenerate

    // A flush seen during lookup forces the miss path, so stale lines are never returned.
    assign hit_any = (|hit_vec) && !ifu.flush;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    // Descending scan so the lowest-index invalid way wins; otherwise round-robin.
    always_comb begin
        victim_next      = rr_reg[set_idx];
        victim_was_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[set_idx][w]) begin
                victim_next      = WAY_W'(w);
                victim_was_valid = 1'b0;
            end
        end
    end

    assign rr_next = (rr_reg[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[set_idx] + 1'b1;

    assign rd_way  = (state_reg == S_LOOKUP) ? hit_way : victim_reg;
    assign rd_word = data_reg[set_idx][rd_way][word_sel];

    always_comb begin
        resp_inst_next = pc_reg[2] ? rd_word[63:32] : rd_word[31:0];
        if (state_reg == S_LOOKUP && misaligned) resp_inst_next = EBREAK;
    end

    assign last_beat = (beat_reg == WORD_W'(LINE_WORDS - 1));

    assign ifu.req_ready  = (state_reg == S_IDLE) && !ifu.flush;
    assign ifu.resp_valid = ((state_reg == S_LOOKUP) && (misaligned || hit_any)) ||
                            (state_reg == S_RESP);
    assign ifu.resp_inst  = ifu.resp_valid ? resp_inst_next : resp_inst_reg;

    assign mem.mem_req_valid = mem_req_valid_reg;
    assign mem.mem_req_addr  = mem_req_addr_reg;
    assign hit_cnt           = hit_cnt_reg;
    assign miss_cnt          = miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            pc_reg            <= '0;
            victim_reg        <= '0;
            beat_reg          <= '0;
            flush_seen_reg    <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            resp_inst_reg     <= '0;
            hit_cnt_reg       <= '0;
            miss_cnt_reg      <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid_reg[s][w] <= 1'b0;
            end
        end else begin
            if (ifu.resp_valid) resp_inst_reg <= resp_inst_next;

            case (state_reg)
                S_IDLE: begin
                    if (ifu.req_valid && ifu.req_ready) begin
                        pc_reg    <= ifu.req_pc;
                        state_reg <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (misaligned) begin
                        state_reg <= S_IDLE;
                    end else if (hit_any) begin
                        hit_cnt_reg <= hit_cnt_reg + 32'd1;
                        state_reg   <= S_IDLE;
                    end else begin
                        miss_cnt_reg      <= miss_cnt_reg + 32'd1;
                        victim_reg        <= victim_next;
                        if (victim_was_valid) rr_reg[set_idx] <= rr_next;
                        mem_req_valid_reg <= 1'b1;
                        mem_req_addr_reg  <= {pc_tag, set_idx, {OFF_W{1'b0}}};
                        flush_seen_reg    <= 1'b0;
                        state_reg         <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (ifu.flush) flush_seen_reg <= 1'b1;
                    if (mem.mem_req_ready) begin
                        mem_req_valid_reg <= 1'b0;
                        beat_reg          <= '0;
                        state_reg         <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ifu.flush) flush_seen_reg <= 1'b1;
                    if (mem.mem_rsp_valid) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (last_beat) begin
                            if (!flush_seen_reg && !ifu.flush) valid_reg[set_idx][victim_reg] <= 1'b1;
                            state_reg <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // Placed last so a same-edge flush overrides the valid set above.
            if (ifu.flush) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_reg[s] <= '0;
                    for (int w = 0; w < WAYS; w++) valid_reg[s][w] <= 1'b0;
                end
            end
        end
    end

    // Tag is written together with the last beat so a partial line never matches.
    always_ff @(posedge clk) begin
        if (state_reg == S_REFILL && mem.mem_rsp_valid) begin
            data_reg[set_idx][victim_reg][beat_reg] <= mem.mem_rsp_data;
            if (last_beat) tag_reg[set_idx][victim_reg] <= pc_tag;
        end
    end
endmodule
